// File: rtl/dds_table_cfg_ctrl_if.sv
// dds_table_cfg_ctrl_if: host command stream plus table-write / control outputs
// of the DDS table configuration sequencer.
// Optional: LOAD_CHECKSUM_EN adds the load_sum checksum signal.
interface dds_table_cfg_ctrl_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 48
);
    logic              load_start;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_cmd;
    logic [15:0]       cfg_data;
    logic              cen;
    logic              wen;
    logic [ADDR_W-1:0] index_wri;
    logic [DATA_W-1:0] D;
    logic [15:0]       fcw;
    logic [15:0]       offset;
    logic              loaded;
    logic              err;
`ifdef LOAD_CHECKSUM_EN
    logic [15:0]       load_sum;
`endif

    // Host / bench side.
    modport master (
        output load_start, cfg_valid, cfg_cmd, cfg_data,
        input  cfg_ready, cen, wen, index_wri, D, fcw, offset, loaded, err
`ifdef LOAD_CHECKSUM_EN
        , input load_sum
`endif
    );

    // Sequencer side.
    modport slave (
        input  load_start, cfg_valid, cfg_cmd, cfg_data,
        output cfg_ready, cen, wen, index_wri, D, fcw, offset, loaded, err
`ifdef LOAD_CHECKSUM_EN
        , output load_sum
`endif
    );
endinterface

// File: rtl/dds_table_cfg_ctrl.sv
// dds_table_cfg_ctrl: assembles 48-bit PAC table entries from three 16-bit
// host beats, writes all DEPTH entries, then enables the table (cen). fcw and
// offset are staged in shadow registers and applied together on commit.
// Optional: define LOAD_CHECKSUM_EN to add load_sum, the modulo-2^16 sum of
// table beats accepted since the last load_start.
module dds_table_cfg_ctrl #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 48
) (
    input logic                 clk,
    input logic                 reset,
    dds_table_cfg_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    logic [1:0]        beat_q;
    logic [ADDR_W-1:0] index_q;
    logic [DATA_W-1:0] d_q;
    logic              wen_q;
    logic              cen_q;
    logic              loaded_q;
    logic              err_q;
    logic [15:0]       fcw_q;
    logic [15:0]       offset_q;
    logic [15:0]       fcw_sh_q;
    logic [15:0]       offset_sh_q;
`ifdef LOAD_CHECKSUM_EN
    logic [15:0]       sum_q;
`endif
    logic              cfg_ready;
    logic              accept;

    // Beats are refused while a table write is in flight or a restart is taken.
    always_comb begin
        cfg_ready = (state_q != WRITE) && !bus.load_start;
        accept    = bus.cfg_valid && cfg_ready;
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            index_q     <= '0;
            d_q         <= '0;
            wen_q       <= 1'b0;
            cen_q       <= 1'b0;
            loaded_q    <= 1'b0;
            err_q       <= 1'b0;
            fcw_q       <= '0;
            offset_q    <= '0;
            fcw_sh_q    <= '0;
            offset_sh_q <= '0;
`ifdef LOAD_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            wen_q <= 1'b0;
            if (bus.load_start) begin
                // Restart wins over any beat; an in-flight WRITE already drove its wen.
                state_q  <= LOAD;
                beat_q   <= '0;
                index_q  <= '0;
                cen_q    <= 1'b0;
                loaded_q <= 1'b0;
                err_q    <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
                sum_q    <= '0;
`endif
            end else begin
                case (state_q)
                    LOAD: begin
                        if (accept && bus.cfg_cmd == 2'b00) begin
                            case (beat_q)
                                2'd0:    d_q[15:0]  <= bus.cfg_data;
                                2'd1:    d_q[31:16] <= bus.cfg_data;
                                default: d_q[47:32] <= bus.cfg_data;
                            endcase
`ifdef LOAD_CHECKSUM_EN
                            sum_q <= sum_q + bus.cfg_data;
`endif
                            if (beat_q == 2'd2) begin
                                beat_q  <= '0;
                                wen_q   <= 1'b1;
                                state_q <= WRITE;
                            end else begin
                                beat_q <= beat_q + 2'd1;
                            end
                        end
                    end
                    WRITE: begin
                        if (index_q == LAST_IDX) begin
                            state_q  <= RUN;
                            cen_q    <= 1'b1;
                            loaded_q <= 1'b1;
                        end else begin
                            index_q <= index_q + ADDR_W'(1);
                            state_q <= LOAD;
                        end
                    end
                    default: ;
                endcase

                if (accept) begin
                    case (bus.cfg_cmd)
                        2'b00: if (state_q != LOAD) err_q <= 1'b1;
                        2'b01: fcw_sh_q    <= bus.cfg_data;
                        2'b10: offset_sh_q <= bus.cfg_data;
                        default: begin
                            fcw_q    <= fcw_sh_q;
                            offset_q <= offset_sh_q;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.cfg_ready = cfg_ready;
    assign bus.cen       = cen_q;
    assign bus.wen       = wen_q;
    assign bus.index_wri = index_q;
    assign bus.D         = d_q;
    assign bus.fcw       = fcw_q;
    assign bus.offset    = offset_q;
    assign bus.loaded    = loaded_q;
    assign bus.err       = err_q;
`ifdef LOAD_CHECKSUM_EN
    assign bus.load_sum  = sum_q;
`endif
endmodule

// File: tb/tb_dds_table_cfg_ctrl.sv
// tb_dds_table_cfg_ctrl: directed and randomized stimulus for the DDS table
// configuration sequencer, checked every cycle against a transaction-level
// model (beat queue, entry counter) plus literal expectations.
module tb_dds_table_cfg_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dds_table_cfg_ctrl_if #(.ADDR_W(6), .DATA_W(48)) bus ();
    dds_table_cfg_ctrl #(.DEPTH(64), .ADDR_W(6), .DATA_W(48)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int unsigned n_pass = 0;
    int unsigned n_tot  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit          m_load, m_wen, m_cen, m_loaded, m_err, m_acc, m_ls;
    int          m_entry;
    logic [15:0] m_fcw, m_off, m_fsh, m_osh, m_sum;
    logic [15:0] m_beats[$];
    logic [47:0] m_D;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_load = 0; m_wen = 0; m_cen = 0; m_loaded = 0; m_err = 0;
            m_entry = 0; m_fcw = 0; m_off = 0; m_fsh = 0; m_osh = 0; m_sum = 0;
            m_D = 0; m_beats.delete();
        end else begin
            m_ls  = bus.load_start;
            m_acc = bus.cfg_valid && !m_ls && !m_wen;
            if (m_ls) begin
                m_load = 1; m_wen = 0; m_entry = 0; m_cen = 0; m_loaded = 0;
                m_err = 0; m_sum = 0; m_beats.delete();
            end else begin
                if (m_wen) begin
                    m_wen = 0;
                    if (m_entry == 63) begin
                        m_cen = 1; m_loaded = 1; m_load = 0;
                    end else m_entry++;
                end
                if (m_acc) begin
                    case (bus.cfg_cmd)
                        2'b00: if (m_load) begin
                            m_beats.push_back(bus.cfg_data);
                            m_sum += bus.cfg_data;
                            if (m_beats.size() == 3) begin
                                m_D = {m_beats[2], m_beats[1], m_beats[0]};
                                m_beats.delete();
                                m_wen = 1;
                            end
                        end else m_err = 1;
                        2'b01: m_fsh = bus.cfg_data;
                        2'b10: m_osh = bus.cfg_data;
                        default: begin m_fcw = m_fsh; m_off = m_osh; end
                    endcase
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit lit_on = 0;
    int lit_k  = 0;

    initial forever begin
        @(negedge clk);
        chk("cfg_ready", bus.cfg_ready, !m_wen && !bus.load_start);
        chk("wen", bus.wen, m_wen);
        if (bus.wen) begin
            chk("index_wri", bus.index_wri, m_entry);
            chk("D", bus.D, m_D);
        end
        chk("cen", bus.cen, m_cen);
        chk("loaded", bus.loaded, m_loaded);
        chk("err", bus.err, m_err);
        chk("fcw", bus.fcw, m_fcw);
        chk("offset", bus.offset, m_off);
`ifdef LOAD_CHECKSUM_EN
        chk("load_sum", bus.load_sum, m_sum);
`endif
        if (lit_on && bus.wen) begin
            chk("lit_index", bus.index_wri, lit_k);
            chk("lit_D", bus.D, {16'(3*lit_k+2), 16'(3*lit_k+1), 16'(3*lit_k)});
            lit_k++;
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [1:0] c, input logic [15:0] d);
        int unsigned n = 0;
        bit got = 0;
        bus.cfg_cmd = c; bus.cfg_data = d; bus.cfg_valid = 1'b1;
        while (!got && n < 20) begin
            @(negedge clk);
            got = bus.cfg_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!got) begin
            n_tot++;
            $display("FAIL send_timeout: cfg_ready low for %0d cycles, required acceptance", n);
        end
        bus.cfg_valid = 1'b0;
    endtask

    task automatic pulse_ls();
        bus.load_start = 1'b1;
        @(posedge clk); #1;
        bus.load_start = 1'b0;
    endtask

    initial begin
        bus.load_start = 0; bus.cfg_valid = 0; bus.cfg_cmd = 0; bus.cfg_data = 0;
        #1;
        chk("rst_cen", bus.cen, 0);
        chk("rst_wen", bus.wen, 0);
        chk("rst_index", bus.index_wri, 0);
        chk("rst_D", bus.D, 0);
        chk("rst_ready", bus.cfg_ready, 1);
        chk("rst_loaded", bus.loaded, 0);
        #22 reset = 0;
        @(posedge clk); #1;

        // Full load with data = beat index.
        pulse_ls();
        lit_on = 1; lit_k = 0;
        for (int i = 0; i < 192; i++) send(2'b00, 16'(i));
        chk("last_wen", bus.wen, 1);
        chk("cen_pre", bus.cen, 0);
        @(posedge clk); #1;
        chk("cen_n2", bus.cen, 1);
        chk("loaded_n2", bus.loaded, 1);
        chk("wen_off", bus.wen, 0);
        lit_on = 0;
        chk("wen_count", lit_k, 64);

        // Shadow registers and commit.
        send(2'b01, 16'h1234);
        send(2'b10, 16'h0040);
        chk("fcw_hold", bus.fcw, 16'h0000);
        chk("off_hold", bus.offset, 16'h0000);
        send(2'b11, 16'h0000);
        chk("fcw_commit", bus.fcw, 16'h1234);
        chk("off_commit", bus.offset, 16'h0040);

        // Table beat while running.
        send(2'b00, 16'hDEAD);
        chk("err_run", bus.err, 1);
        chk("cen_run", bus.cen, 1);
        pulse_ls();
        chk("err_clr", bus.err, 0);
        chk("cen_clr", bus.cen, 0);

        // Abort after entry 10 plus two beats.
        for (int i = 0; i < 32; i++) send(2'b00, 16'(16'h0100 + i));
        pulse_ls();
        send(2'b00, 16'h00A0); send(2'b00, 16'h00A1); send(2'b00, 16'h00A2);
        chk("abort_wen", bus.wen, 1);
        chk("abort_idx", bus.index_wri, 0);
        chk("abort_D", bus.D, 48'h00A2_00A1_00A0);

        // load_start coincident with a valid beat.
        bus.load_start = 1; bus.cfg_valid = 1; bus.cfg_cmd = 2'b00; bus.cfg_data = 16'h5555;
        @(negedge clk);
        chk("ls_ready", bus.cfg_ready, 0);
        @(posedge clk); #1;
        bus.load_start = 0; bus.cfg_valid = 0;
        send(2'b00, 16'h0B00); send(2'b00, 16'h0B01); send(2'b00, 16'h0B02);
        chk("coin_idx", bus.index_wri, 0);
        chk("coin_D", bus.D, 48'h0B02_0B01_0B00);

        // Reset asserted during the WRITE cycle.
        #2 reset = 1;
        #1;
        chk("arst_wen", bus.wen, 0);
        chk("arst_cen", bus.cen, 0);
        chk("arst_idx", bus.index_wri, 0);
        chk("arst_loaded", bus.loaded, 0);
        @(posedge clk); #1 reset = 0;

        // Randomized traffic.
        pulse_ls();
        for (int c = 0; c < 4000; c++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            bus.load_start = ($urandom_range(0, 599) == 0);
            bus.cfg_valid  = ($urandom_range(0, 9) < 8);
            bus.cfg_cmd    = (r < 90) ? 2'b00 : (r < 94) ? 2'b01 : (r < 97) ? 2'b10 : 2'b11;
            bus.cfg_data   = 16'($urandom);
            @(posedge clk); #1;
        end
        bus.load_start = 0; bus.cfg_valid = 0;

        // Full load of constant beats.
        pulse_ls();
        for (int i = 0; i < 192; i++) send(2'b00, 16'h0101);
        @(posedge clk); #1;
        chk("final_loaded", bus.loaded, 1);
`ifdef LOAD_CHECKSUM_EN
        chk("sum_lit", bus.load_sum, 16'hC0C0);
        repeat (3) @(posedge clk);
        #1 chk("sum_stable", bus.load_sum, 16'hC0C0);
`endif
        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/dds_table_cfg_ctrl.md
Name: dds_table_cfg_ctrl

Overview:
Configuration sequencer for the 16-bit CORDIC/DDS pipe (phase accumulator, phase compression, PAC sine table).
- Accepts a 16-bit host command stream.
- Assembles 48-bit table entries from three beats and writes all 64 PAC entries via index_wri/D/wen.
- Gates the table enable (cen) until loading completes.
- Holds fcw/offset in shadow registers and applies them atomically on a commit command.

Parameters:
DEPTH, 64, number of table entries written per load
ADDR_W, 6, table index width
DATA_W, 48, table entry width (3 x 16-bit beats)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
load_start  input  1  single-cycle pulse; (re)starts a table load at index 0
cfg_valid  input  1  host beat valid
cfg_ready  output  1  beat accepted when cfg_valid & cfg_ready
cfg_cmd  input  2  00 table beat, 01 fcw shadow, 10 offset shadow, 11 commit
cfg_data  input  16  beat payload
cen  output  1  table enable to PAC, high only in RUN
wen  output  1  table write strobe, one cycle per entry
index_wri  output  ADDR_W  table write address
D  output  DATA_W  table write data
fcw  output  16  active frequency control word
offset  output  16  active phase offset
loaded  output  1  high once a full table load has completed
err  output  1  sticky error flag

Behaviour:
- Reset values: cen=0, wen=0, index_wri=0, D=0, fcw=0, offset=0, loaded=0, err=0, shadows=0, beat count=0, state=IDLE. cfg_ready=1 in IDLE after reset.
- States: IDLE, LOAD, WRITE, RUN.
- IDLE/RUN + load_start -> LOAD: index=0, beat count=0, cen=0, loaded=0, err cleared.
- LOAD, cmd 00 accepted: beats fill D in order [15:0], [31:16], [47:32]. On the third beat -> WRITE next cycle.
- WRITE, one cycle:
  - wen=1; index_wri and D registered and stable; cfg_ready=0.
  - Next cycle wen=0.
  - If index_wri was DEPTH-1 -> RUN: cen=1, loaded=1.
  - Otherwise index increments and state returns to LOAD.
- Latency: third beat accepted at cycle n -> wen=1 at n+1; after the last entry, cen=1 at n+2.
- cmd 01/10: writes the fcw/offset shadow. Accepted in any state except WRITE; fcw/offset outputs unchanged.
- cmd 11: fcw<=fcw shadow and offset<=offset shadow together, visible the cycle after acceptance. Legal in any state except WRITE.
- cmd 00 outside LOAD: beat accepted and discarded; err<=1.
- load_start during LOAD or WRITE: abort. Next state LOAD at index 0, partial beats discarded. A WRITE cycle coinciding with load_start still completes its wen.
- load_start with cfg_valid in the same cycle: load_start wins; cfg_ready=0 that cycle, beat not accepted.
- Reset mid-load: all state cleared immediately; cen=0, loaded=0.
- index_wri never exceeds DEPTH-1; no wrap without load_start.
- cfg_ready=1 in all states except WRITE and load_start cycles.

Optional Feature:
Macro: LOAD_CHECKSUM_EN.
- Defined: adds output load_sum[15:0], the modulo-2^16 sum of all cmd-00 beats accepted in LOAD since the last load_start.
  - Reset value 0; cleared on load_start.
  - Stable once loaded=1.
- Undefined: port and adder absent; all other behaviour identical.

Test Plan:
- Reset, load_start, 192 beats with data=beat index (0..191) -> 64 wen pulses. Entry k has D={3k+2,3k+1,3k} and index_wri=k. cen=1 and loaded=1 two cycles after beat 191.
- cmd01 0x1234, cmd10 0x0040, then cmd11 -> fcw=0x1234, offset=0x0040 exactly one cycle after the commit; unchanged after cmd01/10 alone.
- load_start after entry 10 plus 2 beats -> restart. Next wen has index_wri=0 with the new beats; the 2 stale beats are absent from D.
- cmd00 beat in RUN -> err=1, table not written, cen stays 1. Next load_start clears err.
- load_start coincident with cfg_valid -> cfg_ready=0 that cycle; beat not counted. Reset asserted mid-WRITE -> wen=0, cen=0, index_wri=0 asynchronously.
- LOAD_CHECKSUM_EN defined, 192 beats of 0x0101 -> load_sum=0xC0C0 (192 x 0x0101 mod 2^16).
